// File: rtl/oram_pkg.sv
// Shared widths, request record and sequencer state encoding for the ORAM front-end.
package oram_pkg;

   localparam int A = 8;
   localparam int D = 6;
   localparam int W = 8 * A;

   typedef struct packed {
      logic [D-1:0] block;
      logic [W-1:0] wdata;
      logic         rw;
   } oram_req_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } oram_fsm_t;

endpackage

// File: rtl/oram_req_fifo.sv
// Synchronous request FIFO; pushes when full and pops when empty are dropped.
module oram_req_fifo
   import oram_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  oram_req_t                din,
   output oram_req_t                dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   oram_req_t        mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // pointers are exactly PW bits wide, so wrap is the natural overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/oram_req_sequencer.sv
// Client-facing request sequencer: queues requests and drives the ORAM core one access at a time.
//
// state | meaning
// IDLE  | waiting for a queued request; pops the FIFO head into the issue register
// ISSUE | one-cycle input_ready pulse to the core; timer cleared
// WAIT  | waiting for core output_ready or timeout
// RESP  | response presented to client until resp_ready
module oram_req_sequencer
   import oram_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [D-1:0]                  req_block,
   input  logic [W-1:0]                  req_wdata,
   input  logic                          req_rw,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic [W-1:0]                  resp_rdata,
   output logic                          resp_rw,
   output logic [D-1:0]                  resp_block,
   output logic                          resp_error,
   output logic [D-1:0]                  oram_block,
   output logic [W-1:0]                  oram_wdata,
   output logic                          oram_rw,
   output logic                          oram_input_ready,
   input  logic [W-1:0]                  oram_r_value,
   input  logic                          oram_output_ready,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   pending
);

   localparam int              TW     = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]   T_MAX  = '1;

   oram_fsm_t   state;
   logic [TW-1:0] timer;
   oram_req_t   fifo_din;
   oram_req_t   fifo_head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_push;
   logic        fifo_pop;

   assign fifo_din  = '{block: req_block, wdata: req_wdata, rw: req_rw};
   assign req_ready = !fifo_full;
   assign fifo_push = req_valid && req_ready;
   assign fifo_pop  = (state == IDLE) && !fifo_empty;
   assign busy      = (state != IDLE) || !fifo_empty;

   oram_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (pending)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         timer            <= '0;
         oram_block       <= '0;
         oram_wdata       <= '0;
         oram_rw          <= 1'b0;
         oram_input_ready <= 1'b0;
         resp_valid       <= 1'b0;
         resp_rdata       <= '0;
         resp_rw          <= 1'b0;
         resp_block       <= '0;
         resp_error       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  oram_block       <= fifo_head.block;
                  oram_wdata       <= fifo_head.wdata;
                  oram_rw          <= fifo_head.rw;
                  oram_input_ready <= 1'b1;
                  state            <= ISSUE;
               end
            end
            ISSUE: begin
               oram_input_ready <= 1'b0;
               timer            <= '0;
               state            <= WAIT;
            end
            WAIT: begin
               // a completion arriving on the timeout cycle still counts as success
               if (oram_output_ready) begin
                  resp_rdata <= oram_rw ? '0 : oram_r_value;
                  resp_error <= 1'b0;
                  resp_rw    <= oram_rw;
                  resp_block <= oram_block;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else if (timer == T_LAST) begin
                  resp_rdata <= '0;
                  resp_error <= 1'b1;
                  resp_rw    <= oram_rw;
                  resp_block <= oram_block;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else if (timer != T_MAX) begin
                  timer <= timer + 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_oram_req_sequencer.sv
// Directed bench for oram_req_sequencer with a simple hand-driven core model.
module tb_oram_req_sequencer;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [5:0]    req_block = '0;
   logic [63:0]   req_wdata = '0;
   logic          req_rw = 1'b0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [63:0]   resp_rdata;
   logic          resp_rw;
   logic [5:0]    resp_block;
   logic          resp_error;
   logic [5:0]    oram_block;
   logic [63:0]   oram_wdata;
   logic          oram_rw;
   logic          oram_input_ready;
   logic [63:0]   oram_r_value = '0;
   logic          oram_output_ready = 1'b0;
   logic          busy;
   logic [2:0]    pending;

   int tests_run = 0;
   int fails = 0;
   int pulse_cnt = 0;

   oram_req_sequencer #(
      .FIFO_DEPTH (4),
      .TIMEOUT    (16)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_block         (req_block),
      .req_wdata         (req_wdata),
      .req_rw            (req_rw),
      .resp_valid        (resp_valid),
      .resp_ready        (resp_ready),
      .resp_rdata        (resp_rdata),
      .resp_rw           (resp_rw),
      .resp_block        (resp_block),
      .resp_error        (resp_error),
      .oram_block        (oram_block),
      .oram_wdata        (oram_wdata),
      .oram_rw           (oram_rw),
      .oram_input_ready  (oram_input_ready),
      .oram_r_value      (oram_r_value),
      .oram_output_ready (oram_output_ready),
      .busy              (busy),
      .pending           (pending)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (oram_input_ready) pulse_cnt++;
   end

   task automatic push_one(input logic [5:0] blk, input logic [63:0] wd, input logic rw);
      @(negedge clk);
      req_block = blk;
      req_wdata = wd;
      req_rw    = rw;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_pulse(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (oram_input_ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic serve(input int lat, input logic [63:0] val);
      repeat (lat) @(posedge clk);
      #1;
      oram_r_value      = val;
      oram_output_ready = 1'b1;
      @(posedge clk);
      #1;
      oram_output_ready = 1'b0;
      oram_r_value      = '0;
   endtask

   task automatic accept();
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if ({req_ready, resp_valid, oram_input_ready, pending, busy} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_ctrl cycle %0d: ready=%b rvalid=%b ir=%b pending=%0d busy=%b, need 1 0 0 0 0",
                     i, req_ready, resp_valid, oram_input_ready, pending, busy);
         end
      end
      tests_run++;
      if ({resp_rdata, resp_rw, resp_block, resp_error, oram_block, oram_wdata, oram_rw} !== '0) begin
         fails++;
         $display("FAIL reset_data: rdata=%h block=%h oram_block=%h oram_wdata=%h, need all 0",
                  resp_rdata, resp_block, oram_block, oram_wdata);
      end
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read();
      bit ok;
      int p0;
      p0 = pulse_cnt;
      push_one(6'h05, 64'h0, 1'b0);
      wait_pulse(ok);
      tests_run++;
      if (!ok) begin
         fails++;
         $display("FAIL read_pulse: no input_ready pulse within 40 cycles");
      end
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (resp_valid !== 1'b0) begin
         fails++;
         $display("FAIL read_early: resp_valid=%b before core answered, need 0", resp_valid);
      end
      oram_r_value      = 64'h1122334455667788;
      oram_output_ready = 1'b1;
      @(posedge clk);
      #1;
      oram_output_ready = 1'b0;
      oram_r_value      = '0;
      tests_run++;
      if ({resp_valid, resp_rdata, resp_rw, resp_block, resp_error} !==
          {1'b1, 64'h1122334455667788, 1'b0, 6'h05, 1'b0}) begin
         fails++;
         $display("FAIL read_resp: valid=%b rdata=%h rw=%b block=%h err=%b, need 1 1122334455667788 0 05 0",
                  resp_valid, resp_rdata, resp_rw, resp_block, resp_error);
      end
      tests_run++;
      if (pulse_cnt - p0 !== 1) begin
         fails++;
         $display("FAIL read_pulse_count: %0d pulse cycles, need 1", pulse_cnt - p0);
      end
      accept();
      tests_run++;
      if ({resp_valid, busy} !== 2'b00) begin
         fails++;
         $display("FAIL read_accept: resp_valid=%b busy=%b, need 0 0", resp_valid, busy);
      end
   endtask

   task automatic test_write_backpressure();
      bit ok;
      push_one(6'h3F, 64'hDEADBEEF00000001, 1'b1);
      wait_pulse(ok);
      tests_run++;
      if (!ok || {oram_block, oram_wdata, oram_rw} !== {6'h3F, 64'hDEADBEEF00000001, 1'b1}) begin
         fails++;
         $display("FAIL write_issue: pulse=%b block=%h wdata=%h rw=%b, need 1 3f deadbeef00000001 1",
                  ok, oram_block, oram_wdata, oram_rw);
      end
      serve(2, 64'hA5A5A5A5A5A5A5A5);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests_run++;
         if ({resp_valid, resp_rdata, resp_rw, resp_block, resp_error} !==
             {1'b1, 64'h0, 1'b1, 6'h3F, 1'b0}) begin
            fails++;
            $display("FAIL write_hold cycle %0d: valid=%b rdata=%h rw=%b block=%h err=%b, need 1 0 1 3f 0",
                     i, resp_valid, resp_rdata, resp_rw, resp_block, resp_error);
         end
      end
      accept();
      tests_run++;
      if (resp_valid !== 1'b0) begin
         fails++;
         $display("FAIL write_accept: resp_valid=%b, need 0", resp_valid);
      end
   endtask

   task automatic test_full_fifo();
      bit ok;
      int p0;
      push_one(6'h2A, 64'h0, 1'b0);
      wait_pulse(ok);
      serve(1, 64'h0102030405060708);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_block = 6'(i);
         req_wdata = 64'h0;
         req_rw    = 1'b0;
         req_valid = 1'b1;
         tests_run++;
         if (req_ready !== (i < 4)) begin
            fails++;
            $display("FAIL full_ready push %0d: req_ready=%b, need %b", i, req_ready, (i < 4));
         end
         @(posedge clk);
      end
      @(negedge clk);
      req_valid = 1'b0;
      tests_run++;
      if ({pending, req_ready, resp_valid, resp_block} !== {3'd4, 1'b0, 1'b1, 6'h2A}) begin
         fails++;
         $display("FAIL full_state: pending=%0d ready=%b rvalid=%b rblock=%h, need 4 0 1 2a",
                  pending, req_ready, resp_valid, resp_block);
      end
      accept();
      for (int i = 0; i < 4; i++) begin
         wait_pulse(ok);
         tests_run++;
         if (!ok || oram_block !== 6'(i)) begin
            fails++;
            $display("FAIL full_issue %0d: pulse=%b oram_block=%h, need 1 %h", i, ok, oram_block, 6'(i));
         end
         serve(1, {56'h0, 8'(i + 8'h40)});
         tests_run++;
         if ({resp_valid, resp_block, resp_rdata, resp_error} !== {1'b1, 6'(i), {56'h0, 8'(i + 8'h40)}, 1'b0}) begin
            fails++;
            $display("FAIL full_order %0d: valid=%b block=%h rdata=%h err=%b, need 1 %h %h 0",
                     i, resp_valid, resp_block, resp_rdata, resp_error, 6'(i), 8'(i + 8'h40));
         end
         accept();
      end
      p0 = pulse_cnt;
      repeat (5) @(negedge clk);
      tests_run++;
      if ({pending, busy} !== 4'b0000 || pulse_cnt != p0) begin
         fails++;
         $display("FAIL full_drain: pending=%0d busy=%b extra pulses=%0d, need 0 0 0",
                  pending, busy, pulse_cnt - p0);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int cnt;
      push_one(6'h11, 64'h0, 1'b0);
      push_one(6'h12, 64'h0, 1'b0);
      wait_pulse(ok);
      tests_run++;
      if (!ok || oram_block !== 6'h11) begin
         fails++;
         $display("FAIL tmo_issue: pulse=%b oram_block=%h, need 1 11", ok, oram_block);
      end
      @(posedge clk);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 cnt++;
         if (resp_valid) break;
      end
      tests_run++;
      if (cnt !== 16 || {resp_valid, resp_error, resp_rdata, resp_block} !== {1'b1, 1'b1, 64'h0, 6'h11}) begin
         fails++;
         $display("FAIL tmo_resp: cycles=%0d valid=%b err=%b rdata=%h block=%h, need 16 1 1 0 11",
                  cnt, resp_valid, resp_error, resp_rdata, resp_block);
      end
      accept();
      wait_pulse(ok);
      tests_run++;
      if (!ok || oram_block !== 6'h12) begin
         fails++;
         $display("FAIL tmo_next_issue: pulse=%b oram_block=%h, need 1 12", ok, oram_block);
      end
      serve(2, 64'h00000000CAFEF00D);
      tests_run++;
      if ({resp_valid, resp_error, resp_rdata, resp_block} !== {1'b1, 1'b0, 64'h00000000CAFEF00D, 6'h12}) begin
         fails++;
         $display("FAIL tmo_next_resp: valid=%b err=%b rdata=%h block=%h, need 1 0 cafef00d 12",
                  resp_valid, resp_error, resp_rdata, resp_block);
      end
      accept();
   endtask

   task automatic test_reset_mid_wait();
      int p0;
      int bad;
      push_one(6'h21, 64'h0, 1'b0);
      push_one(6'h22, 64'h0, 1'b0);
      push_one(6'h23, 64'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({pending, busy, resp_valid} !== {3'd2, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL rstw_pre: pending=%0d busy=%b rvalid=%b, need 2 1 0", pending, busy, resp_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if ({pending, busy, resp_valid, oram_input_ready, req_ready} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL rstw_reset: pending=%0d busy=%b rvalid=%b ir=%b ready=%b, need 0 0 0 0 1",
                  pending, busy, resp_valid, oram_input_ready, req_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      p0 = pulse_cnt;
      bad = 0;
      oram_r_value      = 64'hFFFF0000FFFF0000;
      oram_output_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (resp_valid) bad++;
      end
      oram_output_ready = 1'b0;
      oram_r_value      = '0;
      tests_run++;
      if (bad != 0 || pulse_cnt != p0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL rstw_post: resp cycles=%0d pulses=%0d busy=%b, need 0 0 0", bad, pulse_cnt - p0, busy);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write_backpressure();
      test_full_fifo();
      test_timeout();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/oram_req_sequencer.md
Name: oram_req_sequencer

Overview:
- Upstream front-end for the ORAM core; client request side uses valid/ready.
- Buffers read/write requests in a small FIFO and issues them to the core one at a time.
- Waits for the core's completion and returns one response per request: read data for reads, acknowledge for writes.
- Guards each core access with a timeout so a hung access cannot stall the client.

Parameters:
A, 8, bytes per block (data width = 8*A bits)
D, 6, block-number width in bits
FIFO_DEPTH, 4, request FIFO entries (power of two, >=2)
TIMEOUT, 1024, max cycles in WAIT before an access is aborted

Ports:
clk  in  1  core clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
req_valid  in  1  client request valid
req_ready  out  1  FIFO can accept (not full)
req_block  in  D  requested block number
req_wdata  in  8*A  write value (ignored for reads)
req_rw  in  1  0=read, 1=write
resp_valid  out  1  response valid
resp_ready  in  1  client accepts response
resp_rdata  out  8*A  read data (0 for writes and for errors)
resp_rw  out  1  echo of request rw
resp_block  out  D  echo of request block number
resp_error  out  1  1 = access timed out
oram_block  out  D  to core rw_block_number
oram_wdata  out  8*A  to core w_value
oram_rw  out  1  to core rw_indicator
oram_input_ready  out  1  to core input_ready; exactly one-cycle pulse per access
oram_r_value  in  8*A  from core r_value
oram_output_ready  in  1  from core output_ready
busy  out  1  FSM not in IDLE or FIFO non-empty
pending  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, async): FIFO emptied, pending=0, FSM=IDLE, timer=0.
  - All outputs 0 except req_ready=1.
  - Reset mid-access drops the in-flight request silently; no response is produced.
- Enqueue: on a clk edge with req_valid&&req_ready, push {block,wdata,rw}.
  - req_ready = (pending != FIFO_DEPTH).
  - When full, req_ready=0 and the push is ignored.
- Simultaneous push and pop with FIFO non-empty: both occur; pending unchanged.
  - Push into an empty FIFO is not visible to the FSM until the next cycle (no bypass).
- FSM IDLE: if FIFO non-empty, pop head into the issue register (oram_block/oram_wdata/oram_rw) -> ISSUE.
  - The issue register holds its value until the next pop.
- ISSUE (1 cycle): oram_input_ready=1; timer cleared -> WAIT.
- WAIT: oram_input_ready=0; timer increments each cycle.
  - If oram_output_ready=1: capture resp_rdata = oram_rw ? 0 : oram_r_value; resp_error=0; echo rw/block -> RESP.
  - Else if timer==TIMEOUT-1: resp_rdata=0, resp_error=1 -> RESP.
  - output_ready on the same cycle as the timeout wins (success).
  - output_ready outside WAIT is ignored.
- RESP: resp_valid=1; all resp_* fields held stable while resp_valid=1 and resp_ready=0.
  - On resp_ready=1: resp_valid falls next cycle -> IDLE.
- Latency: with FIFO empty and the core answering L cycles after the input_ready pulse:
  - req handshake at edge 0; pop at edge 1; input_ready high during cycle 1->2.
  - resp_valid rises L+1 cycles after the input_ready pulse.
- Ordering: strictly in order; at most one outstanding core access.
- Timer width: $clog2(TIMEOUT)+1; the timer saturates and does not wrap.
- FIFO pointers: $clog2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH.

Decomposition:
- Package oram_pkg holds:
  - shared constants A, D;
  - typedef oram_req_t {block, wdata, rw};
  - typedef fsm enum {IDLE, ISSUE, WAIT, RESP}.
- Sub-module oram_req_fifo: parameterised synchronous FIFO of oram_req_t with push/pop/full/empty/count and active-low async reset.
- The FSM, timer and response registers live in the top.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 -> req_ready=1, resp_valid=0, oram_input_ready=0, pending=0 throughout.
- Read: push read of block 0x05; core returns 0x1122334455667788 with output_ready 3 cycles after the input_ready pulse -> one input_ready pulse; then resp_valid with resp_rdata=0x1122334455667788, resp_rw=0, resp_block=0x05, resp_error=0.
- Write ack and backpressure: write block 0x3F, value 0xDEADBEEF00000001; resp_ready held 0 for 5 cycles -> oram_wdata matches; resp fields stable for 5 cycles; resp_rdata=0, resp_rw=1.
- Full FIFO: push 5 requests back-to-back with the core stalled -> 4 accepted; req_ready=0 on the 5th; pending=4; responses return in push order with block numbers 0,1,2,3.
- Timeout with TIMEOUT=16: core never asserts output_ready -> resp_error=1 and resp_rdata=0, 16 cycles after the pulse; the next queued request then issues normally.
- Reset mid-WAIT: assert rst=0 while in WAIT with 2 requests queued -> no response produced; pending=0; core output_ready after reset release is ignored.
